// File: rtl/seg_pkg.sv
// Shared types and frame layout for the segment-scan master.
package seg_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StShift,
      StTail,
      StDwell
   } scan_state_e;

   localparam int unsigned COL_MSB     = 7;
   localparam int unsigned SCR_MSB     = 5;
   localparam int unsigned DIG_MSB     = 3;
   localparam int unsigned NUM_SCREENS = 4;

   // Frame byte {column, screen, digit}; column select tracks the screen index.
   function automatic logic [7:0] build_frame(input logic [1:0] scr, input logic [3:0] dig);
      logic [7:0] frame;
      frame                = '0;
      frame[COL_MSB -: 2]  = scr;
      frame[SCR_MSB -: 2]  = scr;
      frame[DIG_MSB -: 4]  = dig;
      return frame;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Per-column key debouncer: a level change needs DEBOUNCE consecutive disagreeing samples.
module key_debounce #(
   parameter int unsigned DEBOUNCE = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic sample_en,
   input  logic raw,
   output logic state,
   output logic press
);

   localparam int unsigned     CntW    = $clog2(DEBOUNCE + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE - 1);

   logic [CntW-1:0] cnt_q, cnt_d;
   logic            state_q, state_d;
   logic            press_q, press_d;

   // Next-state: count disagreeing samples, toggle on the DEBOUNCE-th one.
   always_comb begin
      cnt_d   = cnt_q;
      state_d = state_q;
      press_d = 1'b0;
      if (sample_en) begin
         if (raw != state_q) begin
            if (cnt_q == CntLast) begin
               state_d = ~state_q;
               cnt_d   = '0;
               press_d = ~state_q;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end else begin
            cnt_d = '0;
         end
      end
   end

   // State registers; press is registered so it lines up with the state edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         state_q <= 1'b0;
         press_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         state_q <= state_d;
         press_q <= press_d;
      end
   end

   assign state = state_q;
   assign press = press_q;

endmodule

// File: rtl/seg_scan_master.sv
// Scans four screens into the SPI-fed segment decoder and debounces the returned key line.
module seg_scan_master
   import seg_pkg::*;
#(
   parameter int unsigned CLK_DIV     = 4,
   parameter int unsigned HOLD_CYCLES = 1024,
   parameter int unsigned DEBOUNCE    = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       run,
   input  logic       wr_en,
   input  logic [1:0] wr_addr,
   input  logic [3:0] wr_data,
   output logic       sck,
   output logic       sdo,
   output logic       en,
   input  logic       miso,
   output logic [3:0] key_state,
   output logic [3:0] key_press,
   output logic       busy
);

   // One counter serves both the sck half-period and the dwell.
   localparam int unsigned     CntMax   = (HOLD_CYCLES > CLK_DIV) ? HOLD_CYCLES : CLK_DIV;
   localparam int unsigned     CntW     = $clog2(CntMax);
   localparam logic [CntW-1:0] DivLast  = CntW'(CLK_DIV - 1);
   localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CYCLES - 1);

   scan_state_e     state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shreg_q, shreg_d;
   logic [1:0]      scr_q, scr_d;
   logic            sck_q, sck_d;
   logic            sdo_q, sdo_d;
   logic            en_q, en_d;
   logic            sample;
   logic            miso_meta_q, miso_sync_q;
   logic [3:0]      digit_q [NUM_SCREENS];

   // Host digit writes; a frame already in the shifter is unaffected.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_SCREENS; i++) digit_q[i] <= '0;
      end else if (wr_en) begin
         digit_q[wr_addr] <= wr_data;
      end
   end

   // Two-flop synchronizer for the asynchronous key return.
   always_ff @(posedge clk) begin
      if (rst) begin
         miso_meta_q <= 1'b0;
         miso_sync_q <= 1'b0;
      end else begin
         miso_meta_q <= miso;
         miso_sync_q <= miso_meta_q;
      end
   end

   // Scan FSM next-state and registered serial outputs.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      scr_d   = scr_q;
      sck_d   = sck_q;
      sdo_d   = sdo_q;
      en_d    = en_q;
      sample  = 1'b0;
      unique case (state_q)
         StIdle: begin
            sck_d = 1'b0;
            en_d  = 1'b0;
            if (run) state_d = StLoad;
         end
         StLoad: begin
            shreg_d = build_frame(scr_q, digit_q[scr_q]);
            sdo_d   = shreg_d[7];
            en_d    = 1'b1;
            sck_d   = 1'b0;
            cnt_d   = '0;
            bit_d   = '0;
            state_d = StShift;
         end
         StShift: begin
            if (cnt_q == DivLast) begin
               cnt_d = '0;
               if (!sck_q) begin
                  sck_d = 1'b1;
               end else begin
                  sck_d = 1'b0;
                  if (bit_q == 3'd7) begin
                     state_d = StTail;
                  end else begin
                     // Next bit goes out on the sck falling edge.
                     bit_d   = bit_q + 3'd1;
                     shreg_d = {shreg_q[6:0], 1'b0};
                     sdo_d   = shreg_q[6];
                  end
               end
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StTail: begin
            if (cnt_q == DivLast) begin
               cnt_d   = '0;
               en_d    = 1'b0;
               state_d = StDwell;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StDwell: begin
            if (cnt_q == HoldLast) begin
               cnt_d   = '0;
               sample  = 1'b1;
               scr_d   = scr_q + 2'd1;
               state_d = run ? StLoad : StIdle;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // FSM and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         scr_q   <= '0;
         sck_q   <= 1'b0;
         sdo_q   <= 1'b0;
         en_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         scr_q   <= scr_d;
         sck_q   <= sck_d;
         sdo_q   <= sdo_d;
         en_q    <= en_d;
      end
   end

   // The selected column reads low when its key is pressed.
   for (genvar c = 0; c < NUM_SCREENS; c++) begin : g_col
      key_debounce #(
         .DEBOUNCE(DEBOUNCE)
      ) u_debounce (
         .clk      (clk),
         .rst      (rst),
         .sample_en(sample && (scr_q == 2'(c))),
         .raw      (~miso_sync_q),
         .state    (key_state[c]),
         .press    (key_press[c])
      );
   end

   assign sck  = sck_q;
   assign sdo  = sdo_q;
   assign en   = en_q;
   assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_seg_scan_master.sv
// Directed bench for seg_scan_master with a posedge-sck decoder model and a scripted key line.
module tb_seg_scan_master;

   localparam int unsigned CLK_DIV = 2;
   localparam int unsigned HOLD    = 8;
   localparam int unsigned DEB     = 3;
   localparam int unsigned PERIOD  = 43;

   logic       clk     = 1'b0;
   logic       rst     = 1'b1;
   logic       run     = 1'b0;
   logic       wr_en   = 1'b0;
   logic [1:0] wr_addr = '0;
   logic [3:0] wr_data = '0;
   logic       sck, sdo, en, miso, busy;
   logic [3:0] key_state, key_press;

   always #5 clk = ~clk;

   seg_scan_master #(
      .CLK_DIV    (CLK_DIV),
      .HOLD_CYCLES(HOLD),
      .DEBOUNCE   (DEB)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .run      (run),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .sck      (sck),
      .sdo      (sdo),
      .en       (en),
      .miso     (miso),
      .key_state(key_state),
      .key_press(key_press),
      .busy     (busy)
   );

   int n_checks = 0;
   int n_fails  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Decoder model: shift on sck rise, latch on en fall.
   int         cyc        = 0;
   int         rises      = 0;
   int         last_rises = 0;
   logic [7:0] sh         = '0;
   logic [7:0] fq [$];
   int         rq [$];
   int         tq [$];
   logic [3:0] key_mask   = '0;
   logic       key_low    = 1'b0;

   assign miso = ~key_low;

   always @(negedge clk) cyc <= cyc + 1;

   always @(posedge sck) begin
      sh    <= {sh[6:0], sdo};
      rises <= rises + 1;
   end

   // Key line is pulled low during the dwell after frames of masked columns.
   always @(en) begin
      if (en === 1'b1) begin
         key_low <= 1'b0;
      end else if (rst === 1'b0) begin
         fq.push_back(sh);
         rq.push_back(rises - last_rises);
         tq.push_back(cyc);
         key_low    <= key_mask[sh[5:4]];
         last_rises <= rises;
      end else begin
         last_rises <= rises;
      end
   end

   // Press pulse bookkeeping.
   int         npress        = 0;
   logic [3:0] last_press    = '0;
   logic       press_edge_ok = 1'b0;
   logic [3:0] ks_prev       = '0;

   always @(negedge clk) begin
      if (key_press != 4'b0000) begin
         npress        <= npress + 1;
         last_press    <= key_press;
         press_edge_ok <= ((key_state & ~ks_prev) == key_press);
      end
      ks_prev <= key_state;
   end

   task automatic wait_frame(output logic [7:0] b, output int r, output int t);
      int n;
      n = 0;
      while (fq.size() == 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (fq.size() == 0) begin
         check("frame_timeout", 32'd0, 32'd1);
         b = '0;
         r = 0;
         t = 0;
      end else begin
         b = fq.pop_front();
         r = rq.pop_front();
         t = tq.pop_front();
      end
   endtask

   task automatic wait_en_high();
      int n;
      n = 0;
      while (en !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("en_rise_timeout", 32'(en === 1'b1), 32'd1);
   endtask

   initial begin
      logic [7:0] b;
      logic [7:0] expb;
      logic [3:0] dig [4];
      int         r, t, t_prev, n, r0;
      for (int i = 0; i < 4; i++) dig[i] = '0;
      t_prev = 0;

      repeat (3) @(negedge clk);
      check("rst_sck", 32'(sck), 32'd0);
      check("rst_sdo", 32'(sdo), 32'd0);
      check("rst_en", 32'(en), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_key_state", 32'(key_state), 32'd0);
      check("rst_key_press", 32'(key_press), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      run = 1'b1;

      for (int k = 0; k < 40; k++) begin
         wait_frame(b, r, t);
         expb = {2'(k), 2'(k), dig[k % 4]};
         check($sformatf("byte[%0d]", k), 32'(b), 32'(expb));
         check($sformatf("rises[%0d]", k), 32'(r), 32'd8);
         if (k > 0) check($sformatf("period[%0d]", k), 32'(t - t_prev), PERIOD);
         t_prev = t;
         case (k)
            0: check("busy_running", 32'(busy), 32'd1);
            5: begin
               key_mask = 4'b0010;
               wait_en_high();
               @(negedge clk);
               wr_en   = 1'b1;
               wr_addr = 2'd2;
               wr_data = 4'hA;
               @(negedge clk);
               wr_addr = 2'd3;
               wr_data = 4'h7;
               @(negedge clk);
               wr_en   = 1'b0;
            end
            6: begin
               dig[2] = 4'hA;
               dig[3] = 4'h7;
            end
            14: check("key_after_2", 32'(key_state), 32'h0);
            17: key_mask = 4'b0000;
            18: begin
               check("key_after_3", 32'(key_state), 32'h2);
               check("press_count", 32'(npress), 32'd1);
               check("press_value", 32'(last_press), 32'h2);
               check("press_on_edge", 32'(press_edge_ok), 32'd1);
            end
            19: key_mask = 4'b0001;
            24: key_mask = 4'b0000;
            26: check("glitch_hold", 32'(key_state), 32'h2);
            30: check("release_and_glitch", 32'(key_state), 32'h0);
            31: key_mask = 4'b0001;
            36: key_mask = 4'b0000;
            37: begin
               check("glitch_cleared", 32'(key_state), 32'h0);
               check("press_count_2", 32'(npress), 32'd1);
            end
            default: ;
         endcase
      end

      // Stop mid-frame: frame completes, full dwell, then idle.
      wait_frame(b, r, t);
      check("byte_f40", 32'(b), 32'h00);
      wait_en_high();
      repeat (3) @(negedge clk);
      run = 1'b0;
      wait_frame(b, r, t);
      check("byte_stop", 32'(b), 32'h50);
      check("rises_stop", 32'(r), 32'd8);
      n = 0;
      while (busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("dwell_len", 32'(n), HOLD);
      check("idle_en", 32'(en), 32'd0);
      check("idle_sck", 32'(sck), 32'd0);
      r0 = rises;
      repeat (60) @(negedge clk);
      check("idle_rises", 32'(rises - r0), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_frames", 32'(fq.size()), 32'd0);
      run = 1'b1;
      wait_frame(b, r, t);
      check("byte_resume", 32'(b), 32'hAA);
      check("rises_resume", 32'(r), 32'd8);

      // Reset mid-shift.
      wait_en_high();
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_en", 32'(en), 32'd0);
      check("mid_rst_sck", 32'(sck), 32'd0);
      check("mid_rst_key", 32'(key_state), 32'h0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      check("mid_rst_no_frame", 32'(fq.size()), 32'd0);
      wait_frame(b, r, t);
      check("byte_post_rst0", 32'(b), 32'h00);
      check("rises_post_rst0", 32'(r), 32'd8);
      wait_frame(b, r, t);
      check("byte_post_rst1", 32'(b), 32'h50);
      wait_frame(b, r, t);
      check("byte_post_rst2", 32'(b), 32'hA0);
      wait_frame(b, r, t);
      check("byte_post_rst3", 32'(b), 32'hF0);
      check("press_total", 32'(npress), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/seg_scan_master.md
# seg_scan_master

Upstream controller for the SPI-fed segment decoder. It holds four 4-bit digit values written by the host and continuously scans screens 0..3. For each screen it shifts one 8-bit frame {column, screen, digit} into the decoder and latches it with a falling `en`. It then samples the decoder's returned key line and produces debounced per-column key state and one-cycle press pulses.

## Interface
- `CLK_DIV`, default 4: `clk` cycles per `sck` half-period; must be ≥1.
- `HOLD_CYCLES`, default 1024: dwell cycles with `en` low after each frame; must be ≥4.
- `DEBOUNCE`, default 4: consecutive agreeing samples needed to change a key state; must be ≥1.
- `clk` in 1: single clock; every register is clocked on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `run` in 1: enables scanning. When low, the block finishes the current frame and dwell, then idles.
- `wr_en` in 1: host digit write strobe.
- `wr_addr` in 2: screen index to write.
- `wr_data` in 4: digit value.
- `sck` out 1: serial clock to the decoder; idles low.
- `sdo` out 1: serial data, MSB first.
- `en` out 1: frame enable; its falling edge latches the frame.
- `miso` in 1: decoder key return; active-low, meaning low = key pressed in the selected column.
- `key_state` out 4: debounced key level per column; 1 = pressed.
- `key_press` out 4: one-`clk` pulse on a debounced 0→1 transition.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- Reset: `sck`=0, `sdo`=0, `en`=0, `busy`=0, `key_state`=0, `key_press`=0. Digit registers, screen index, counters, debounce counters and `miso` synchronizer all clear to 0. FSM goes to IDLE.
- Digit write: `wr_en` writes `wr_data` into digit[`wr_addr`] on the same edge. The write is visible from the next LOAD of that screen. A frame already loaded is unaffected.
- Frame byte: {scr[1:0], scr[1:0], digit[scr]}. The column select equals the screen index, so each frame scans one keypad column.
- FSM states:
  - IDLE → LOAD when `run`=1.
  - LOAD, 1 cycle: capture the frame byte. `en`←1, `sdo`←bit7, `sck`=0.
  - SHIFT: 8 bits. Each bit is CLK_DIV cycles with `sck` low, then CLK_DIV cycles with `sck` high. `sdo` changes only on the cycle `sck` goes low, on bit 2 onward. After the 8th high phase, go to TAIL.
  - TAIL: CLK_DIV cycles with `sck`=0 and `en`=1, then `en`←0, then go to DWELL.
  - DWELL: HOLD_CYCLES cycles with `en`=0. On the last cycle, sample the synchronized `miso` as raw key[scr] = ~miso_sync. Then increment scr mod 4 (3 wraps to 0). Next state is LOAD if `run`=1, else IDLE.
- `run` falling mid-frame does not abort the frame. `run` is only examined at the end of DWELL and in IDLE.
- `miso` passes through a 2-flop synchronizer before any use.
- Debounce, per column c, evaluated only at that column's sample point:
  - If raw ≠ key_state[c], increment cnt[c].
  - Otherwise clear cnt[c].
  - When cnt[c] reaches DEBOUNCE, toggle key_state[c] and clear cnt[c].
  - A 0→1 toggle raises key_press[c] for exactly one `clk`.
  - Counter width is clog2(DEBOUNCE+1).
- `rst` asserted in any state returns the block to the reset values on the next edge. No partial frame is completed, and `en` drops immediately.

## Timing
- Frame period = 1 + 16·CLK_DIV + CLK_DIV + HOLD_CYCLES cycles.
- Setup and hold around `sck`:
  - `sdo` is stable CLK_DIV cycles before each `sck` rising edge and CLK_DIV cycles after it.
  - `en` rises at least CLK_DIV cycles before the first `sck` rise.
  - `en` falls CLK_DIV cycles after the last `sck` fall.
- Exactly 8 `sck` rising edges occur per `en` high window.
- Key sample latency: the `miso` value present at DWELL cycle HOLD_CYCLES−3 or later is the one sampled, because of the 2-flop synchronizer.
- Key state latency: `key_state` changes on the sample edge of the DEBOUNCE-th consecutive disagreeing sample for that column. That is at least (DEBOUNCE−1) full 4-frame scans after the first such sample.
- `key_press` coincides with the `key_state` 0→1 edge.

## Structure
- Shared package `seg_pkg`:
  - FSM state enum (IDLE, LOAD, SHIFT, TAIL, DWELL).
  - Frame field positions: COL_MSB=7, SCR_MSB=5, DIG_MSB=3.
  - NUM_SCREENS=4.
- Sub-module `key_debounce`, instantiated 4 times: ports `clk`, `rst`, `sample_en`, `raw`, `state`, `press`, with parameter DEBOUNCE.

## Test plan
Parameters: CLK_DIV=2, HOLD_CYCLES=8, DEBOUNCE=3. Frame period = 43 cycles.
- Reset then `run`=1 with all digits 0: capture 4 frames in a model of the decoder's `posedge sck` shifter. Expect bytes 0x00, 0x50, 0xA0, 0xF0 in order. Each frame has exactly 8 `sck` rises, and `en` falls 43 cycles apart.
- Write 0xA to addr 2 and 0x7 to addr 3 while screen 2 is in SHIFT. The current frame stays 0xA0. The next screen-2 frame is 0xAA, and the screen-3 frame in the same pass is 0xF7.
- Hold `miso`=0 only while `en` is low after screen-1 frames. key_state[1] rises after the 3rd screen-1 sample, with key_press=4'b0010 for one cycle. Other columns stay 0.
- Glitch: `miso` low for 2 consecutive screen-0 samples, then high. key_state[0] stays 0 and no pulse occurs.
- Drop `run` during SHIFT of screen 1. The frame completes with 8 rises and the full dwell, `busy` falls, and `en`/`sck` stay 0. Re-raising `run` resumes at screen 2.
- Assert `rst` for 1 cycle mid-SHIFT. On the next edge `en`=0, `sck`=0, `key_state`=0, and digits are cleared. The next frame is screen 0, byte 0x00.
